// File: rtl/udp_ip_fragmenter.sv
// udp_ip_fragmenter: prepends a UDP header to a payload stream and drives the IP
// frame-send engine once per fragment of at most MAX_FRAG bytes.
module udp_ip_fragmenter #(
  parameter int          MAX_FRAG    = 1480,
  parameter logic [15:0] PKT_ID_INIT = 16'h0000,
  parameter logic [7:0]  PROTOCOL    = 8'd17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_vld,
  output logic        o_cmd_rdy,
  input  logic [15:0] i_cmd_len,
  input  logic [15:0] i_src_port,
  input  logic [15:0] i_dst_port,
  input  logic [31:0] i_pl_data,
  input  logic        i_pl_vld,
  output logic        o_pl_rdy,
  output logic        o_sync,
  input  logic        i_eng_ready,
  output logic        o_more_frame,
  output logic [15:0] o_pkt_id,
  output logic [15:0] o_frame_size,
  output logic [15:0] o_frame_offset,
  output logic [7:0]  o_protocol,
  output logic [31:0] o_eng_data,
  output logic        o_eng_vld,
  input  logic        i_eng_rdy,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);
  typedef enum logic [2:0] {IDLE, CALC, SYNC, ACK, HDR0, HDR1, DATA, WAIT_RDY} state_t;
  localparam logic [15:0] MF = 16'(MAX_FRAG);
  state_t state_q, state_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d, rem_q, rem_d, off_q, off_d;
  logic [15:0] fsize_q, fsize_d, foff_q, foff_d, cnt_q, cnt_d, pkt_id_q, pkt_id_d;
  logic        first_q, first_d, more_q, more_d, done_q, done_d, err_q, err_d;
  logic        accept, xfer, frag_end, data_live;
  logic [15:0] cmd_len, fs;
  assign cmd_len   = i_cmd_len & 16'hFFFC;
  assign fs        = rem_q > MF ? MF : rem_q;
  assign accept    = i_cmd_vld && o_cmd_rdy;
  assign xfer      = o_eng_vld && i_eng_rdy;
  assign data_live = state_q == DATA && cnt_q != 16'd0;
  // an empty first fragment (L=0) reaches DATA with nothing left and ends without a transfer
  assign frag_end  = state_q == DATA && (cnt_q == 16'd0 || (xfer && cnt_q == 16'd1));
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = accept && cmd_len <= 16'd65504 ? CALC : IDLE;
      CALC:     state_d = SYNC;
      SYNC:     state_d = i_eng_ready ? ACK : SYNC;
      ACK:      state_d = i_eng_ready ? ACK : first_q ? HDR0 : DATA;
      HDR0:     state_d = xfer ? HDR1 : HDR0;
      HDR1:     state_d = xfer ? DATA : HDR1;
      DATA:     state_d = frag_end ? (more_q ? WAIT_RDY : IDLE) : DATA;
      WAIT_RDY: state_d = i_eng_ready ? CALC : WAIT_RDY;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      off_q    <= '0;
      fsize_q  <= '0;
      foff_q   <= '0;
      cnt_q    <= '0;
      pkt_id_q <= PKT_ID_INIT;
      first_q  <= 1'b0;
      more_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      off_q    <= off_d;
      fsize_q  <= fsize_d;
      foff_q   <= foff_d;
      cnt_q    <= cnt_d;
      pkt_id_q <= pkt_id_d;
      first_q  <= first_d;
      more_q   <= more_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    rem_d    = rem_q;
    off_d    = off_q;
    fsize_d  = fsize_q;
    foff_d   = foff_q;
    cnt_d    = cnt_q;
    pkt_id_d = pkt_id_q;
    first_d  = first_q;
    more_d   = more_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (accept) begin
      src_d   = i_src_port;
      dst_d   = i_dst_port;
      len_d   = cmd_len;
      rem_d   = cmd_len + 16'd8;
      off_d   = '0;
      first_d = 1'b1;
      err_d   = cmd_len > 16'd65504;
    end
    if (state_q == CALC) begin
      fsize_d = fs;
      more_d  = rem_q > MF;
      foff_d  = off_q;
      cnt_d   = fs >> 2;
    end
    if (xfer) cnt_d = cnt_q - 16'd1;
    if (frag_end) begin
      rem_d    = rem_q - fsize_q;
      off_d    = off_q + fsize_q;
      first_d  = 1'b0;
      done_d   = !more_q;
      pkt_id_d = more_q ? pkt_id_q : pkt_id_q + 16'd1;
    end
  end
  always_comb begin
    o_cmd_rdy  = state_q == IDLE;
    o_busy     = state_q != IDLE;
    o_sync     = state_q == ACK;
    o_eng_vld  = state_q == HDR0 || state_q == HDR1 || (data_live && i_pl_vld);
    o_pl_rdy   = data_live && i_eng_rdy;
    o_eng_data = state_q == HDR0 ? {src_q, dst_q} :
                 state_q == HDR1 ? {len_q + 16'd8, 16'h0000} : i_pl_data;
  end
  assign o_more_frame   = more_q;
  assign o_pkt_id       = pkt_id_q;
  assign o_frame_size   = fsize_q;
  assign o_frame_offset = foff_q;
  assign o_protocol     = PROTOCOL;
  assign o_done         = done_q;
  assign o_err          = err_q;
endmodule

// File: tb/tb_udp_ip_fragmenter.sv
// tb_udp_ip_fragmenter: directed bench with a cycle-stepped engine and payload source model.
module tb_udp_ip_fragmenter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        i_cmd_vld = 1'b0, o_cmd_rdy;
  logic [15:0] i_cmd_len = '0, i_src_port = '0, i_dst_port = '0;
  logic [31:0] i_pl_data = '0;
  logic        i_pl_vld = 1'b0, o_pl_rdy, o_sync, i_eng_ready = 1'b1, o_more_frame;
  logic [15:0] o_pkt_id, o_frame_size, o_frame_offset;
  logic [7:0]  o_protocol;
  logic [31:0] o_eng_data;
  logic        o_eng_vld, i_eng_rdy = 1'b0, o_busy, o_done, o_err;
  int checks = 0, failures = 0, pl_idx = 0, exp_idx = 0;

  udp_ip_fragmenter dut (
    .clk(clk), .rst(rst), .i_cmd_vld(i_cmd_vld), .o_cmd_rdy(o_cmd_rdy), .i_cmd_len(i_cmd_len),
    .i_src_port(i_src_port), .i_dst_port(i_dst_port), .i_pl_data(i_pl_data), .i_pl_vld(i_pl_vld),
    .o_pl_rdy(o_pl_rdy), .o_sync(o_sync), .i_eng_ready(i_eng_ready), .o_more_frame(o_more_frame),
    .o_pkt_id(o_pkt_id), .o_frame_size(o_frame_size), .o_frame_offset(o_frame_offset),
    .o_protocol(o_protocol), .o_eng_data(o_eng_data), .o_eng_vld(o_eng_vld), .i_eng_rdy(i_eng_rdy),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pw(input int i);
    return 32'hA500_0000 + 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [15:0] len, input logic [15:0] src, input logic [15:0] dst);
    @(negedge clk);
    i_cmd_vld = 1'b1; i_cmd_len = len; i_src_port = src; i_dst_port = dst;
    #1 chk("cmd_rdy", o_cmd_rdy, 1);
    @(posedge clk);
    #1 i_cmd_vld = 1'b0;
  endtask

  // One fragment: wait for sync, check fields, handshake, then receive size/4 words.
  task automatic do_frag(input int size, input int off, input bit mf, input logic [15:0] pid,
                         input bit hdr, input logic [31:0] h0, input logic [31:0] h1,
                         input bit gaps, input bit last_f, input int stop_at);
    int n, rcv;
    bit got;
    logic [31:0] exp;
    n = size / 4; rcv = 0; got = 1'b0;
    i_eng_ready = 1'b1; i_eng_rdy = 1'b0; i_pl_vld = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      #1 got = o_sync;
    end
    chk("sync_seen", 32'(got), 1);
    if (!got) return;
    chk("frame_size", 32'(o_frame_size), 32'(size));
    chk("frame_offset", 32'(o_frame_offset), 32'(off));
    chk("more_frame", 32'(o_more_frame), 32'(mf));
    chk("pkt_id", 32'(o_pkt_id), 32'(pid));
    chk("protocol", 32'(o_protocol), 32'd17);
    i_eng_ready = 1'b0;
    for (int c = 0; c < n * 10 + 50 && rcv < n && !(stop_at > 0 && rcv >= stop_at); c++) begin
      i_eng_rdy = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      i_pl_vld  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      i_pl_data = pw(pl_idx);
      #1;
      if (!(hdr && rcv < 2) && !i_pl_vld) chk("vld_gap", 32'(o_eng_vld), 0);
      if (o_pl_rdy && i_pl_vld) pl_idx++;
      if (o_eng_vld && i_eng_rdy) begin
        exp = (hdr && rcv == 0) ? h0 : (hdr && rcv == 1) ? h1 : pw(exp_idx);
        chk("word", o_eng_data, exp);
        if (!(hdr && rcv < 2)) exp_idx++;
        rcv++;
      end
      @(negedge clk);
      #1;
    end
    if (stop_at > 0) return;
    chk("word_count", 32'(rcv), 32'(n));
    i_eng_rdy = 1'b0; i_pl_vld = 1'b0;
    chk("size_stable", 32'(o_frame_size), 32'(size));
    if (last_f) begin
      got = 1'b0;
      for (int c = 0; c < 4 && !got; c++) begin
        if (o_done) got = 1'b1;
        else begin
          @(negedge clk);
          #1;
        end
      end
      chk("done", 32'(got), 1);
    end else chk("no_done", 32'(o_done), 0);
    i_eng_ready = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_cmd_rdy", 32'(o_cmd_rdy), 1);
    chk("rst_sync", 32'(o_sync), 0);
    chk("rst_eng_vld", 32'(o_eng_vld), 0);
    chk("rst_pl_rdy", 32'(o_pl_rdy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_pkt_id", 32'(o_pkt_id), 0);
    chk("rst_size", 32'(o_frame_size), 0);
    chk("rst_offset", 32'(o_frame_offset), 0);
    chk("rst_more", 32'(o_more_frame), 0);
    chk("rst_busy", 32'(o_busy), 0);
    // L=100: single fragment of 108 bytes
    send_cmd(16'd100, 16'h1234, 16'h5678);
    do_frag(108, 0, 0, 16'd0, 1, 32'h1234_5678, 32'h006C_0000, 0, 1, 0);
    chk("pl_100", 32'(pl_idx), 32'(exp_idx));
    chk("pl_100_n", 32'(exp_idx), 25);
    // L=3000: three fragments
    send_cmd(16'd3000, 16'hAAAA, 16'h0035);
    do_frag(1480, 0,    1, 16'd1, 1, 32'hAAAA_0035, 32'h0BC0_0000, 0, 0, 0);
    do_frag(1480, 1480, 1, 16'd1, 0, 0, 0, 0, 0, 0);
    do_frag(48,   2960, 0, 16'd1, 0, 0, 0, 0, 1, 0);
    chk("pl_3000", 32'(pl_idx), 32'(exp_idx));
    chk("pl_3000_n", 32'(exp_idx), 775);
    // exact fit and one-word overflow
    send_cmd(16'd1472, 16'h0001, 16'h0002);
    do_frag(1480, 0, 0, 16'd2, 1, 32'h0001_0002, 32'h05C8_0000, 0, 1, 0);
    send_cmd(16'd1476, 16'h0003, 16'h0004);
    do_frag(1480, 0,    1, 16'd3, 1, 32'h0003_0004, 32'h05CC_0000, 0, 0, 0);
    do_frag(4,    1480, 0, 16'd3, 0, 0, 0, 0, 1, 0);
    chk("pl_1476", 32'(pl_idx), 32'(exp_idx));
    chk("pl_1476_n", 32'(exp_idx), 775 + 368 + 369);
    // L=3000 with random engine and payload gaps
    send_cmd(16'd3000, 16'hBEEF, 16'hCAFE);
    do_frag(1480, 0,    1, 16'd4, 1, 32'hBEEF_CAFE, 32'h0BC0_0000, 1, 0, 0);
    do_frag(1480, 1480, 1, 16'd4, 0, 0, 0, 1, 0, 0);
    do_frag(48,   2960, 0, 16'd4, 0, 0, 0, 1, 1, 0);
    chk("pl_gaps", 32'(pl_idx), 32'(exp_idx));
    // oversize command is rejected
    send_cmd(16'd65508, 16'h1111, 16'h2222);
    @(negedge clk);
    #1;
    chk("err_pulse", 32'(o_err), 1);
    chk("err_cmd_rdy", 32'(o_cmd_rdy), 1);
    @(negedge clk);
    #1;
    chk("err_clear", 32'(o_err), 0);
    chk("err_no_sync", 32'(o_sync), 0);
    chk("err_pkt_id", 32'(o_pkt_id), 5);
    // low length bits ignored
    send_cmd(16'd103, 16'h1234, 16'h5678);
    do_frag(108, 0, 0, 16'd5, 1, 32'h1234_5678, 32'h006C_0000, 0, 1, 0);
    // empty datagram: header-only fragment
    send_cmd(16'd0, 16'h0A0B, 16'h0C0D);
    do_frag(8, 0, 0, 16'd6, 1, 32'h0A0B_0C0D, 32'h0008_0000, 0, 1, 0);
    chk("pl_small", 32'(pl_idx), 32'(exp_idx));
    chk("pkt_id_after", 32'(o_pkt_id), 7);
    // reset during DATA of fragment 2
    send_cmd(16'd3000, 16'h4444, 16'h5555);
    do_frag(1480, 0,    1, 16'd7, 1, 32'h4444_5555, 32'h0BC0_0000, 0, 0, 0);
    do_frag(1480, 1480, 1, 16'd7, 0, 0, 0, 0, 0, 10);
    chk("abort_busy", 32'(o_busy), 1);
    rst = 1'b1; i_eng_rdy = 1'b1; i_pl_vld = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_cmd_rdy", 32'(o_cmd_rdy), 1);
    chk("abort_sync", 32'(o_sync), 0);
    chk("abort_pl_rdy", 32'(o_pl_rdy), 0);
    chk("abort_eng_vld", 32'(o_eng_vld), 0);
    chk("abort_pkt_id", 32'(o_pkt_id), 0);
    chk("abort_size", 32'(o_frame_size), 0);
    rst = 1'b0; i_eng_rdy = 1'b0; i_pl_vld = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/udp_ip_fragmenter.md
Name: udp_ip_fragmenter

Overview:
- Sits directly upstream of the IP frame-send engine and drives its sync, header-field and payload-stream inputs.
- Accepts one UDP datagram command (ports, payload length) plus a 32-bit payload stream.
- Prepends the 8-byte UDP header (checksum 0x0000) and splits the UDP datagram into IPv4 fragments of at most MAX_FRAG bytes.
- Sequences the engine once per fragment, supplying pkt_id, more-fragments flag, fragment size and byte offset.

Parameters:
MAX_FRAG, 1480, max IP payload bytes per fragment; multiple of 8, >= 16
PKT_ID_INIT, 16'h0000, pkt_id value after reset
PROTOCOL, 8'd17, value driven on o_protocol (UDP)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_cmd_vld  in  1  datagram command valid
o_cmd_rdy  out  1  command accepted when vld&&rdy
i_cmd_len  in  16  UDP payload bytes; [1:0] ignored (treated 0)
i_src_port  in  16  UDP source port
i_dst_port  in  16  UDP destination port
i_pl_data  in  32  payload word, first byte in [31:24]
i_pl_vld  in  1  payload valid
o_pl_rdy  out  1  payload accepted when vld&&rdy
o_sync  out  1  start-fragment request to engine (level)
i_eng_ready  in  1  engine idle
o_more_frame  out  1  IP MF flag
o_pkt_id  out  16  IP identification
o_frame_size  out  16  fragment IP payload bytes
o_frame_offset  out  16  fragment byte offset (multiple of 8)
o_protocol  out  8  PROTOCOL
o_eng_data  out  32  data word to engine
o_eng_vld  out  1  data valid to engine
i_eng_rdy  in  1  engine data ready; transfer = o_eng_vld&&i_eng_rdy
o_busy  out  1  state != IDLE
o_done  out  1  1-cycle pulse, last fragment's data complete
o_err  out  1  1-cycle pulse, command rejected

Behaviour:
- Reset (rst high at clk edge):
  - State IDLE; o_sync=0, o_eng_vld=0, o_pl_rdy=0, o_done=0, o_err=0.
  - o_pkt_id=PKT_ID_INIT; o_frame_size/o_frame_offset=0; o_more_frame=0.
  - o_cmd_rdy=1 from the first cycle after reset release.
  - Reset mid-operation aborts immediately; partially consumed payload is not recovered.
- o_cmd_rdy = (state==IDLE). On accept, latch ports and len L = i_cmd_len & 16'hFFFC.
  - If L > 65504: pulse o_err next cycle, stay IDLE, pkt_id unchanged.
  - Otherwise: rem = L+8, offset=0, first=1, go CALC.
- CALC (1 cycle):
  - frame_size = min(rem, MAX_FRAG); more = (rem > MAX_FRAG).
  - Register onto o_frame_size / o_more_frame / o_frame_offset. Word counter = frame_size/4. Go SYNC.
- SYNC: raise o_sync only when i_eng_ready=1, then go ACK.
- ACK: hold o_sync=1 until i_eng_ready observed 0, then drop o_sync and go HDR0 (or DATA if first=0).
  - All o_frame_*/o_pkt_id/o_more_frame/o_protocol stay stable from SYNC until the fragment finishes.
- HDR0: o_eng_data={src_port,dst_port}, o_eng_vld=1; on transfer go HDR1.
- HDR1: o_eng_data={L+8, 16'h0000}, o_eng_vld=1; on transfer go DATA.
- Each header transfer decrements the word counter.
- DATA: combinational pass-through.
  - o_eng_data=i_pl_data; o_eng_vld=i_pl_vld; o_pl_rdy=i_eng_rdy.
  - Decrement the counter on each transfer. The transfer with counter==1 ends the fragment.
  - If the counter is already 0 on entry (first fragment of L=0), go straight to the end-of-fragment step.
- End of fragment:
  - rem -= frame_size; offset += frame_size; first=0.
  - If more: go WAIT_RDY, which waits for i_eng_ready=1, then CALC.
  - Else: pulse o_done, pkt_id += 1 (wraps 16 bits), go IDLE.
- Outside DATA: o_pl_rdy=0. Outside HDR0/HDR1/DATA: o_eng_vld=0.
- Header words hold value under backpressure; the payload word is never consumed without an engine transfer.
- Arithmetic: 16-bit unsigned. L<=65504 guarantees rem<=65512 and engine total length (+20) <= 65532.
- Only the first fragment carries the UDP header; its frame_size includes the 8 header bytes.

Test Plan:
- L=100, ports 0x1234/0x5678: one fragment, size 108, offset 0, MF 0, pkt_id 0; words 0x12345678, 0x006C0000, then 25 payload words; o_done; next datagram uses pkt_id 1.
- L=3000: fragments (1480, off 0, MF1), (1480, off 1480, MF1), (48, off 2960, MF0); header only in first; 750 payload words consumed; single o_done.
- L=1472 -> one fragment of 1480, MF0. L=1476 -> 1480 MF1, then 4 bytes at off 1480, MF0, exactly one payload word.
- Random i_eng_rdy and i_pl_vld gaps over L=3000: payload sequence identical to input, no duplication; o_eng_vld low whenever i_pl_vld low in DATA.
- i_cmd_len=65508 -> o_err pulse, no o_sync, o_cmd_rdy high next cycle. i_cmd_len=103 is treated as 100.
- Assert rst during DATA of fragment 2 -> next cycle IDLE, o_sync=0, o_pl_rdy=0, o_pkt_id=PKT_ID_INIT.
